// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multicycle MIPS control FSM
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] PC_S_SEQ = 2'b00;
  localparam logic [1:0] PC_S_REG = 2'b01;
  localparam logic [1:0] PC_S_BR  = 2'b10;
  localparam logic [1:0] PC_S_JMP = 2'b11;

  localparam logic [1:0] WR_RD = 2'b00;
  localparam logic [1:0] WR_RT = 2'b01;
  localparam logic [1:0] WR_RA = 2'b10;

  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_MEM  = 2'b01;
  localparam logic [1:0] WD_LINK = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_BUS     = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEMRD  = 3'd3,
    ST_MEMWR  = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CLS_R_ALU, CLS_I_ALU, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL, CLS_JR
  } cls_e;

endpackage

// File: rtl/mips_mc_decode.sv
// rtl/mips_mc_decode.sv - opcode/funct to instruction class and ALU controls
module mips_mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_e       cls,
  output logic [2:0] alu_op,
  output logic       imm_s,
  output logic       rt_imm_s,
  output logic       legal,
  output logic       ovf_chk
);

  always_comb begin
    cls      = CLS_R_ALU;
    alu_op   = ALU_ADD;
    imm_s    = 1'b1;
    rt_imm_s = 1'b0;
    legal    = 1'b1;
    ovf_chk  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin alu_op = ALU_ADD; ovf_chk = 1'b1; end
          FN_SUB: begin alu_op = ALU_SUB; ovf_chk = 1'b1; end
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          FN_XOR: alu_op = ALU_XOR;
          FN_NOR: alu_op = ALU_NOR;
          FN_SLT: alu_op = ALU_SLT;
          FN_JR:  cls = CLS_JR;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin cls = CLS_I_ALU; rt_imm_s = 1'b1; ovf_chk = 1'b1; end
      OP_SLTI: begin cls = CLS_I_ALU; rt_imm_s = 1'b1; alu_op = ALU_SLT; end
      // Logical immediates are zero-extended.
      OP_ANDI: begin cls = CLS_I_ALU; rt_imm_s = 1'b1; alu_op = ALU_AND; imm_s = 1'b0; end
      OP_ORI:  begin cls = CLS_I_ALU; rt_imm_s = 1'b1; alu_op = ALU_OR;  imm_s = 1'b0; end
      OP_XORI: begin cls = CLS_I_ALU; rt_imm_s = 1'b1; alu_op = ALU_XOR; imm_s = 1'b0; end
      OP_LW:   begin cls = CLS_LW; rt_imm_s = 1'b1; end
      OP_SW:   begin cls = CLS_SW; rt_imm_s = 1'b1; end
      OP_BEQ:  begin cls = CLS_BEQ; alu_op = ALU_SUB; end
      OP_BNE:  begin cls = CLS_BNE; alu_op = ALU_SUB; end
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle control FSM sharing one ram for fetch and data
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zf,
  input  logic       of,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_s,
  output logic       reg_write,
  output logic [1:0] w_r_s,
  output logic [1:0] wr_data_s,
  output logic       rt_imm_s,
  output logic       imm_s,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       ovf_exc,
  output logic [1:0] trap,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       trap_q, trap_d;

  cls_e       dec_cls;
  logic [2:0] dec_alu_op;
  logic       dec_imm_s, dec_rt_imm_s, dec_legal, dec_ovf_chk;
  logic       wait_cyc, ovf_hit, br_taken;

  mips_mc_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .cls      (dec_cls),
    .alu_op   (dec_alu_op),
    .imm_s    (dec_imm_s),
    .rt_imm_s (dec_rt_imm_s),
    .legal    (dec_legal),
    .ovf_chk  (dec_ovf_chk)
  );

  always_comb begin
    state_d    = state_q;
    trap_d     = trap_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_s       = PC_S_SEQ;
    reg_write  = 1'b0;
    w_r_s      = WR_RD;
    wr_data_s  = WD_ALU;
    rt_imm_s   = 1'b0;
    imm_s      = 1'b0;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    ovf_exc    = 1'b0;
    wait_cyc   = 1'b0;
    ovf_hit    = dec_ovf_chk & of;
    br_taken   = (dec_cls == CLS_BEQ) ? zf : ~zf;
    cnt_inc    = cnt_q + 1'b1;

    // IR is stable from EXEC on, so the ALU keeps computing address/result until WB.
    if (state_q inside {ST_EXEC, ST_MEMRD, ST_MEMWR, ST_WB}) begin
      alu_op   = dec_alu_op;
      rt_imm_s = dec_rt_imm_s;
      imm_s    = dec_imm_s;
    end

    case (state_q)
      ST_FETCH: begin
        mem_read = run;
        ir_write = run & mem_ready;
        wait_cyc = run & ~mem_ready;
        if (run && mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          trap_d  = TRAP_ILLEGAL;
        end
      end
      ST_EXEC: begin
        case (dec_cls)
          CLS_LW: state_d = ST_MEMRD;
          CLS_SW: state_d = ST_MEMWR;
          CLS_BEQ, CLS_BNE: begin
            pc_write   = 1'b1;
            pc_s       = br_taken ? PC_S_BR : PC_S_SEQ;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          CLS_J, CLS_JAL: begin
            pc_write   = 1'b1;
            pc_s       = PC_S_JMP;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
            if (dec_cls == CLS_JAL) begin
              reg_write = 1'b1;
              w_r_s     = WR_RA;
              wr_data_s = WD_LINK;
            end
          end
          CLS_JR: begin
            pc_write   = 1'b1;
            pc_s       = PC_S_REG;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        wait_cyc = ~mem_ready;
        if (mem_ready) state_d = ST_WB;
      end
      ST_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        wait_cyc  = ~mem_ready;
        if (mem_ready) begin
          pc_write   = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_WB: begin
        pc_write   = 1'b1;
        instr_done = 1'b1;
        reg_write  = ~ovf_hit;
        ovf_exc    = ovf_hit;
        state_d    = ST_FETCH;
        if (dec_cls == CLS_LW) begin
          w_r_s     = WR_RT;
          wr_data_s = WD_MEM;
        end else if (dec_cls == CLS_I_ALU) begin
          w_r_s = WR_RT;
        end
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    // A ready arriving on the limit cycle clears wait_cyc, so it beats the timeout.
    if (wait_cyc && cnt_inc == WAIT_LIM) begin
      state_d = ST_TRAP;
      trap_d  = TRAP_BUS;
    end

    if (state_d != state_q) cnt_d = '0;
    else if (wait_cyc)      cnt_d = cnt_inc;
    else                    cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
      trap_q  <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
    end
  end

  assign state = state_q;
  assign trap  = trap_q;

endmodule
